// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter.
// Requester 0 is the ALU writeback and requester 1 is the load unit. A 1-bit
// round-robin pointer chooses the winner when both requesters want the single
// write port. The winning write reaches the register file one cycle later as a
// registered address/data/enable triple. A saturating counter records how many
// cycles had both requesters competing for the port.
module regfile_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              reg_wr_en,
    output logic              last_grant,
    output logic [7:0]        contention_cnt
);

    // Requester 0 occupies bit 0 and requester 1 occupies bit 1.
    logic [1:0]        valid_vec;
    logic [1:0]        ready_vec;

    // 0 means requester 0 wins the next contended cycle.
    logic              prio_reg;

    logic              xfer;
    logic              grant_idx;
    logic              contend;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign valid_vec = {req1_valid, req0_valid};

    // Each requester is ready when it is valid and the port is not frozen.
    // The requester must also be alone, or it must own the priority pointer.
    // The reset term keeps both readies low while reset is asserted.
    // No clock edge is needed for the readies to fall at reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            localparam logic MY_IDX = 1'(gi);
            assign ready_vec[gi] = reset_n & ~hold & valid_vec[gi]
                                 & (~valid_vec[1-gi] | (prio_reg == MY_IDX));
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    // At most one ready bit can be high. The chosen index is therefore the
    // requester 1 bit.
    assign xfer      = |ready_vec;
    assign grant_idx = ready_vec[1];

    // Contention counts cycles where both requesters compete and the port is
    // not frozen. A same-address pair counts as contention like any other pair.
    assign contend = req0_valid & req1_valid & ~hold;

    // Select the winning address and data for the write register.
    always_comb begin
        sel_addr = req0_addr;
        sel_data = req0_data;
        if (ready_vec[1]) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
    end

    // The pointer moves to the loser after each transfer.
    // last_grant follows each transfer and holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_reg   <= 1'b0;
            last_grant <= 1'b0;
        end else if (xfer) begin
            prio_reg   <= ~grant_idx;
            last_grant <= grant_idx;
        end
    end

    // The write-enable pulses for exactly one cycle after each transfer.
    // Address and data hold their old values between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_wr_en <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            reg_wr_en <= xfer;
            if (xfer) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    // The contention counter saturates at 255 and never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            contention_cnt <= 8'd0;
        end else if (contend && (contention_cnt != 8'hFF)) begin
            contention_cnt <= contention_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// A behavioural model is checked against the DUT on every falling edge.
// Directed scenarios pin exact values by hand. Randomized traffic follows them.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              hold = 1'b0;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              reg_wr_en;
    logic              last_grant;
    logic [7:0]        contention_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hold           (hold),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .reg_wr_en      (reg_wr_en),
        .last_grant     (last_grant),
        .contention_cnt (contention_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // owner names the requester that wins the next contended cycle.
    // t0 and t1 record which requester transferred on the last edge.
    bit       m_owner;
    bit       m_en;
    int       m_addr;
    int       m_data;
    bit       m_last;
    int       m_cnt;
    bit       m_t0;
    bit       m_t1;

    function automatic bit want_grant(input int i);
        if (!reset_n || hold) return 1'b0;
        if (i == 0) begin
            if (!req0_valid) return 1'b0;
            return !req1_valid || (m_owner == 1'b0);
        end
        if (!req1_valid) return 1'b0;
        return !req0_valid || (m_owner == 1'b1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = 0; m_en = 0; m_addr = 0; m_data = 0;
            m_last = 0; m_cnt = 0; m_t0 = 0; m_t1 = 0;
        end else begin
            m_t0 = want_grant(0);
            m_t1 = want_grant(1);
            if (req0_valid && req1_valid && !hold && m_cnt < 255) m_cnt++;
            m_en = m_t0 || m_t1;
            if (m_t0) begin
                m_addr = int'(req0_addr); m_data = int'(req0_data);
                m_last = 0; m_owner = 1;
            end else if (m_t1) begin
                m_addr = int'(req1_addr); m_data = int'(req1_data);
                m_last = 1; m_owner = 0;
            end
        end
    end

    // Compare the DUT with the model at every falling edge.
    always @(negedge clk) begin
        check("ready0", int'(req0_ready), int'(want_grant(0)));
        check("ready1", int'(req1_ready), int'(want_grant(1)));
        check("reg_wr_en", int'(reg_wr_en), int'(m_en));
        check("wr_addr", int'(wr_addr), m_addr);
        check("wr_data", int'(wr_data), m_data);
        check("last_grant", int'(last_grant), int'(m_last));
        check("contention_cnt", int'(contention_cnt), m_cnt);
    end

    // ---------------- directed and random stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        reset_n = 1'b0;
        hold = 0; req0_valid = 0; req1_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int d);
        if (i == 0) begin
            req0_valid = v; req0_addr = ADDR_W'(a); req0_data = DATA_W'(d);
        end else begin
            req1_valid = v; req1_addr = ADDR_W'(a); req1_data = DATA_W'(d);
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_wr_en", int'(reg_wr_en), 0);
        check("rst_cnt", int'(contention_cnt), 0);
        check("rst_ready0", int'(req0_ready), 0);

        // Single request
        do_reset();
        set_req(0, 1, 2, 8'h5A);
        #2 check("single_ready0", int'(req0_ready), 1);
        next_cycle();
        set_req(0, 0, 0, 0);
        check("single_en_c1", int'(reg_wr_en), 1);
        check("single_addr", int'(wr_addr), 2);
        check("single_data", int'(wr_data), 8'h5A);
        next_cycle();
        check("single_en_c2", int'(reg_wr_en), 0);

        // Contention, both requesters held valid for four cycles
        do_reset();
        set_req(0, 1, 1, 8'h11);
        set_req(1, 1, 3, 8'h33);
        for (int k = 0; k < 4; k++) begin
            #2;
            check("cont_ready0", int'(req0_ready), (k % 2 == 0) ? 1 : 0);
            check("cont_ready1", int'(req1_ready), (k % 2 == 1) ? 1 : 0);
            next_cycle();
            check("cont_en", int'(reg_wr_en), 1);
            check("cont_addr", int'(wr_addr), (k % 2 == 0) ? 1 : 3);
            check("cont_data", int'(wr_data), (k % 2 == 0) ? 8'h11 : 8'h33);
            if (k == 1) check("cont_cnt_after_c1", int'(contention_cnt), 2);
        end
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        next_cycle();
        check("cont_en_end", int'(reg_wr_en), 0);

        // Same address
        do_reset();
        set_req(0, 1, 0, 8'hAA);
        set_req(1, 1, 0, 8'hBB);
        next_cycle();
        set_req(0, 0, 0, 0);
        check("same_en_c1", int'(reg_wr_en), 1);
        check("same_data_c1", int'(wr_data), 8'hAA);
        next_cycle();
        set_req(1, 0, 0, 0);
        check("same_en_c2", int'(reg_wr_en), 1);
        check("same_data_c2", int'(wr_data), 8'hBB);
        check("same_addr_c2", int'(wr_addr), 0);
        next_cycle();
        check("same_en_c3", int'(reg_wr_en), 0);

        // Hold with requester 1 owning priority
        do_reset();
        set_req(0, 1, 1, 8'h01);
        next_cycle();
        hold = 1;
        set_req(0, 1, 2, 8'h42);
        set_req(1, 1, 3, 8'h77);
        check("hold_prev_write", int'(reg_wr_en), 1);
        for (int k = 0; k < 3; k++) begin
            #2;
            check("hold_ready0", int'(req0_ready), 0);
            check("hold_ready1", int'(req1_ready), 0);
            next_cycle();
            check("hold_cnt", int'(contention_cnt), 0);
            check("hold_en", int'(reg_wr_en), 0);
        end
        hold = 0;
        #2;
        check("hold_release_ready1", int'(req1_ready), 1);
        check("hold_release_ready0", int'(req0_ready), 0);
        next_cycle();
        set_req(1, 0, 0, 0);
        check("hold_release_data", int'(wr_data), 8'h77);
        check("hold_release_cnt", int'(contention_cnt), 1);
        set_req(0, 0, 0, 0);

        // Saturation
        do_reset();
        set_req(0, 1, 1, 8'h10);
        set_req(1, 1, 2, 8'h20);
        repeat (300) next_cycle();
        check("sat_cnt_300", int'(contention_cnt), 255);
        repeat (5) next_cycle();
        check("sat_cnt_stay", int'(contention_cnt), 255);

        // Asynchronous reset between edges
        do_reset();
        set_req(0, 1, 3, 8'hC3);
        set_req(1, 1, 2, 8'h3C);
        next_cycle();
        check("areset_pre_en", int'(reg_wr_en), 1);
        #1 reset_n = 1'b0;
        #1;
        check("areset_en", int'(reg_wr_en), 0);
        check("areset_data", int'(wr_data), 0);
        check("areset_cnt", int'(contention_cnt), 0);
        next_cycle();
        reset_n = 1'b1;
        #2 check("areset_first_grant0", int'(req0_ready), 1);
        check("areset_first_grant1", int'(req1_ready), 0);
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);

        // Randomized traffic. A request stays stable until the model
        // records its transfer.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            next_cycle();
            if (!req0_valid || m_t0) begin
                set_req(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                        $urandom_range(0, 255));
            end
            if (!req1_valid || m_t1) begin
                set_req(1, ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                        $urandom_range(0, 255));
            end
            hold = ($urandom_range(0, 4) == 0);
        end
        next_cycle();
        hold = 0;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        repeat (2) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
